// File: rtl/song_select_pkg.sv
// Shared constants for the song-choose screen controller and its VGA panel.
// State encoding, rows per page and the default song-name string width.
package song_select_pkg;

  localparam int NAME_BITS_DEF = 160;
  localparam int ROWS_PER_PAGE = 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/song_page_loader.sv
// Four-read ROM sequencer: fetches the names of one page into row registers.
// Starts busy out of reset so page 0 is fetched as soon as reset releases.
module song_page_loader
  import song_select_pkg::*;
#(
  parameter int NAME_BITS = NAME_BITS_DEF,
  parameter int PAGE_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PAGE_BITS-1:0] page,
  output logic [PAGE_BITS+1:0] rom_addr,
  input  logic [NAME_BITS-1:0] rom_data,
  output logic                 busy,
  output logic                 done,
  output logic [NAME_BITS-1:0] name_0,
  output logic [NAME_BITS-1:0] name_1,
  output logic [NAME_BITS-1:0] name_2,
  output logic [NAME_BITS-1:0] name_3
);

  logic [2:0] cnt;

  // cnt 0..3 drives the address; data for cnt-1 is captured on each step
  assign rom_addr = {page, cnt[1:0]};
  assign done     = busy && (cnt == 3'(ROWS_PER_PAGE));

  // Read sequencer and name capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b1;
      cnt    <= '0;
      name_0 <= '0;
      name_1 <= '0;
      name_2 <= '0;
      name_3 <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      case (cnt)
        3'd1:    name_0 <= rom_data;
        3'd2:    name_1 <= rom_data;
        3'd3:    name_2 <= rom_data;
        3'd4:    name_3 <= rom_data;
        default: ;
      endcase
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/song_select_ctrl.sv
// Song-choose screen controller: cursor/page browsing, page name fetch, selection handshake.
// Define SONG_SEL_WRAP_EN to wrap pages at the ends; otherwise the cursor saturates.
module song_select_ctrl
  import song_select_pkg::*;
#(
  parameter int NAME_BITS  = NAME_BITS_DEF,
  parameter int PAGE_COUNT = 2,
  parameter int PAGE_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic                 key_up,
  input  logic                 key_down,
  input  logic                 key_confirm,
  input  logic                 key_back,
  output logic [PAGE_BITS+1:0] rom_addr,
  input  logic [NAME_BITS-1:0] rom_data,
  output logic [PAGE_BITS-1:0] repertoire_page,
  output logic [1:0]           page_song_id,
  output logic [NAME_BITS-1:0] songname_1,
  output logic [NAME_BITS-1:0] songname_2,
  output logic [NAME_BITS-1:0] songname_3,
  output logic [NAME_BITS-1:0] songname_4,
  output logic                 loading,
  output logic [PAGE_BITS+1:0] sel_song_id,
  output logic                 sel_valid,
  input  logic                 sel_ready
);

  localparam logic [PAGE_BITS-1:0] LAST_PAGE = PAGE_BITS'(PAGE_COUNT - 1);
  localparam logic [PAGE_BITS-1:0] PAGE_ONE  = PAGE_BITS'(1);

  state_t               state, state_nx;
  logic [PAGE_BITS-1:0] page_nx;
  logic [1:0]           row_nx;
  logic                 valid_nx;
  logic [PAGE_BITS+1:0] id_nx;
  logic                 start;
  logic                 done;

  song_page_loader #(
    .NAME_BITS(NAME_BITS),
    .PAGE_BITS(PAGE_BITS)
  ) u_loader (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .page    (page_nx),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy    (loading),
    .done    (done),
    .name_0  (songname_1),
    .name_1  (songname_2),
    .name_2  (songname_3),
    .name_3  (songname_4)
  );

  // State, cursor and selection registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_LOAD;
      repertoire_page <= '0;
      page_song_id    <= '0;
      sel_valid       <= 1'b0;
      sel_song_id     <= '0;
    end else begin
      state           <= state_nx;
      repertoire_page <= page_nx;
      page_song_id    <= row_nx;
      sel_valid       <= valid_nx;
      sel_song_id     <= id_nx;
    end
  end

  // Key decode: confirm beats movement, opposing movement keys cancel
  always_comb begin
    state_nx = state;
    page_nx  = repertoire_page;
    row_nx   = page_song_id;
    valid_nx = sel_valid;
    id_nx    = sel_song_id;
    start    = 1'b0;
    case (state)
      ST_LOAD: begin
        if (done) state_nx = ST_BROWSE;
      end
      ST_BROWSE: begin
        if (active) begin
          if (key_confirm) begin
            id_nx    = {repertoire_page, page_song_id};
            valid_nx = 1'b1;
            state_nx = ST_COMMIT;
          end else if (key_down && !key_up) begin
            if (page_song_id != 2'd3) begin
              row_nx = page_song_id + 2'd1;
            end else if (repertoire_page != LAST_PAGE) begin
              row_nx   = 2'd0;
              page_nx  = repertoire_page + PAGE_ONE;
              start    = 1'b1;
              state_nx = ST_LOAD;
            end
`ifdef SONG_SEL_WRAP_EN
            else begin
              row_nx   = 2'd0;
              page_nx  = '0;
              start    = 1'b1;
              state_nx = ST_LOAD;
            end
`endif
          end else if (key_up && !key_down) begin
            if (page_song_id != 2'd0) begin
              row_nx = page_song_id - 2'd1;
            end else if (repertoire_page != '0) begin
              row_nx   = 2'd3;
              page_nx  = repertoire_page - PAGE_ONE;
              start    = 1'b1;
              state_nx = ST_LOAD;
            end
`ifdef SONG_SEL_WRAP_EN
            else begin
              row_nx   = 2'd3;
              page_nx  = LAST_PAGE;
              start    = 1'b1;
              state_nx = ST_LOAD;
            end
`endif
          end
        end
      end
      ST_COMMIT: begin
        if (sel_ready || key_back) begin
          valid_nx = 1'b0;
          state_nx = ST_BROWSE;
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

endmodule

// File: tb/tb_song_select_ctrl.sv
// Self-checking bench for song_select_ctrl: vector table for browsing,
// hand sequences for selection handshake, back key and resets.
module tb_song_select_ctrl;

  localparam int NB = 160;
  localparam int PB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          active;
  logic          key_up, key_down, key_confirm, key_back;
  logic [PB+1:0] rom_addr;
  logic [NB-1:0] rom_data = '0;
  logic [PB-1:0] repertoire_page;
  logic [1:0]    page_song_id;
  logic [NB-1:0] songname_1, songname_2, songname_3, songname_4;
  logic          loading;
  logic [PB+1:0] sel_song_id;
  logic          sel_valid;
  logic          sel_ready;

  int errors = 0;
  int checks = 0;

  logic [PB+1:0] exp_q[$];
  logic [PB+1:0] hs_exp;
  logic [NB-1:0] names[4];

  typedef struct {
    logic          up;
    logic          down;
    logic [PB-1:0] page;
    logic [1:0]    row;
    logic          load;
  } vec_t;

  vec_t vecs[$];

  song_select_ctrl #(
    .NAME_BITS(NB),
    .PAGE_COUNT(2),
    .PAGE_BITS(PB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .active         (active),
    .key_up         (key_up),
    .key_down       (key_down),
    .key_confirm    (key_confirm),
    .key_back       (key_back),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .repertoire_page(repertoire_page),
    .page_song_id   (page_song_id),
    .songname_1     (songname_1),
    .songname_2     (songname_2),
    .songname_3     (songname_3),
    .songname_4     (songname_4),
    .loading        (loading),
    .sel_song_id    (sel_song_id),
    .sel_valid      (sel_valid),
    .sel_ready      (sel_ready)
  );

  always #5 clk = ~clk;

  // Synchronous name ROM: name = A0 + song index
  always @(posedge clk) rom_data <= NB'(160'hA0) + NB'(rom_addr);

  assign names[0] = songname_1;
  assign names[1] = songname_2;
  assign names[2] = songname_3;
  assign names[3] = songname_4;

  task automatic chk(input string nm, input logic [NB-1:0] act,
                     input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted selection must match the queued expectation
  always @(negedge clk) begin
    if (!rst && sel_valid && sel_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: got id %0d want none", sel_song_id);
      end else begin
        hs_exp = exp_q.pop_front();
        chk("handshake_id", NB'(sel_song_id), NB'(hs_exp));
      end
    end
  end

  task automatic add(input logic u, input logic d, input logic [PB-1:0] p,
                     input logic [1:0] r, input logic l);
    vec_t v;
    v.up = u;
    v.down = d;
    v.page = p;
    v.row = r;
    v.load = l;
    vecs.push_back(v);
  endtask

  task automatic pulse(input logic u, input logic d, input logic c,
                       input logic b);
    key_up = u;
    key_down = d;
    key_confirm = c;
    key_back = b;
    @(posedge clk);
    #1;
    key_up = 0;
    key_down = 0;
    key_confirm = 0;
    key_back = 0;
  endtask

  task automatic wait_load();
    int n = 0;
    while (loading === 1'b1 && n < 12) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("load_cycles", NB'(n), NB'(5));
  endtask

  task automatic check_names(input int p);
    for (int k = 0; k < 4; k++)
      chk($sformatf("songname_%0d", k + 1), names[k],
          NB'(160'hA0) + NB'(p * 4 + k));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    active = 1;
    sel_ready = 0;
    key_up = 0;
    key_down = 0;
    key_confirm = 0;
    key_back = 0;

`ifdef SONG_SEL_WRAP_EN
    add(1, 0, 1, 3, 1);
    add(0, 1, 0, 0, 1);
`else
    add(1, 0, 0, 0, 0);
`endif
    add(0, 1, 0, 1, 0);
    add(0, 1, 0, 2, 0);
    add(0, 1, 0, 3, 0);
    add(0, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0);
    add(1, 0, 0, 3, 1);
    add(0, 1, 1, 0, 1);
    add(0, 1, 1, 1, 0);
    add(0, 1, 1, 2, 0);
    add(0, 1, 1, 3, 0);
`ifdef SONG_SEL_WRAP_EN
    add(0, 1, 0, 0, 1);
    add(1, 0, 1, 3, 1);
`else
    add(0, 1, 1, 3, 0);
`endif
    add(1, 0, 1, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_page", NB'(repertoire_page), '0);
    chk("rst_row", NB'(page_song_id), '0);
    chk("rst_rom_addr", NB'(rom_addr), '0);
    chk("rst_sel_id", NB'(sel_song_id), '0);
    chk("rst_sel_valid", NB'(sel_valid), '0);
    chk("rst_loading", NB'(loading), NB'(1));
    chk("rst_name1", songname_1, '0);
    chk("rst_name4", songname_4, '0);

    rst = 0;
    wait_load();
    check_names(0);
    chk("init_page", NB'(repertoire_page), '0);
    chk("init_row", NB'(page_song_id), '0);

    foreach (vecs[i]) begin
      pulse(vecs[i].up, vecs[i].down, 0, 0);
      chk($sformatf("v%0d_page", i), NB'(repertoire_page), NB'(vecs[i].page));
      chk($sformatf("v%0d_row", i), NB'(page_song_id), NB'(vecs[i].row));
      chk($sformatf("v%0d_loading", i), NB'(loading), NB'(vecs[i].load));
      if (vecs[i].load) begin
        wait_load();
        check_names(int'(vecs[i].page));
      end
    end

    // confirm at page 1 row 2, consumer stalls 3 cycles
    exp_q.push_back(3'd6);
    pulse(0, 0, 1, 0);
    chk("cm_valid_1", NB'(sel_valid), NB'(1));
    chk("cm_id_1", NB'(sel_song_id), NB'(6));
    key_down = 1;
    @(posedge clk);
    #1;
    key_down = 0;
    chk("cm_valid_2", NB'(sel_valid), NB'(1));
    chk("cm_row_hold", NB'(page_song_id), NB'(2));
    @(posedge clk);
    #1;
    chk("cm_valid_3", NB'(sel_valid), NB'(1));
    chk("cm_id_3", NB'(sel_song_id), NB'(6));
    sel_ready = 1;
    chk("cm_valid_4", NB'(sel_valid), NB'(1));
    @(posedge clk);
    #1;
    sel_ready = 0;
    chk("cm_cleared", NB'(sel_valid), '0);
    chk("cm_queue_empty", NB'(exp_q.size()), '0);

    // confirm together with down selects current row; back cancels
    pulse(0, 1, 1, 0);
    chk("cd_valid", NB'(sel_valid), NB'(1));
    chk("cd_id", NB'(sel_song_id), NB'(6));
    chk("cd_row", NB'(page_song_id), NB'(2));
    pulse(0, 0, 0, 1);
    chk("back_valid", NB'(sel_valid), '0);
    pulse(0, 1, 0, 0);
    chk("back_browse_row", NB'(page_song_id), NB'(3));

    // back and ready together: handshake completes
    exp_q.push_back(3'd7);
    pulse(0, 0, 1, 0);
    chk("br_id", NB'(sel_song_id), NB'(7));
    sel_ready = 1;
    pulse(0, 0, 0, 1);
    sel_ready = 0;
    chk("br_valid", NB'(sel_valid), '0);
    chk("br_queue_empty", NB'(exp_q.size()), '0);

    // keys ignored while the menu is hidden
    active = 0;
    pulse(1, 0, 0, 0);
    chk("inactive_row", NB'(page_song_id), NB'(3));
    chk("inactive_page", NB'(repertoire_page), NB'(1));
    active = 1;

    // reset mid-commit drops sel_valid without a clock edge
    pulse(0, 0, 1, 0);
    chk("rc_valid", NB'(sel_valid), NB'(1));
    #2;
    rst = 1;
    #1;
    chk("rc_async_valid", NB'(sel_valid), '0);
    chk("rc_page", NB'(repertoire_page), '0);
    chk("rc_row", NB'(page_song_id), '0);
    @(posedge clk);
    #1;
    rst = 0;

    // reset mid-load, then a fresh page-0 load
    repeat (2) @(posedge clk);
    #1;
    chk("ml_partial_name1", songname_1, NB'(160'hA0));
    chk("ml_loading", NB'(loading), NB'(1));
    rst = 1;
    #1;
    chk("ml_rst_name1", songname_1, '0);
    chk("ml_rst_rom_addr", NB'(rom_addr), '0);
    chk("ml_rst_loading", NB'(loading), NB'(1));
    @(posedge clk);
    #1;
    rst = 0;
    wait_load();
    check_names(0);
    chk("ml_page", NB'(repertoire_page), '0);
    chk("ml_row", NB'(page_song_id), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
